// File: rtl/rgen_apb_command_bridge_if.sv
// Bus bundle between the APB host side and the register-block command side of the bridge.
// The slave modport is the bridge's view; master is the view of whatever drives it.
interface rgen_apb_command_bridge_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
);
    logic                     i_psel;
    logic                     i_penable;
    logic                     i_pwrite;
    logic [ADDRESS_WIDTH-1:0] i_paddr;
    logic [DATA_WIDTH-1:0]    i_pwdata;
    logic                     o_pready;
    logic [DATA_WIDTH-1:0]    o_prdata;
    logic                     o_pslverr;
    logic                     o_command_valid;
    logic                     o_write;
    logic [ADDRESS_WIDTH-1:0] o_address;
    logic [DATA_WIDTH-1:0]    o_write_data;
    logic                     i_response_ready;
    logic [DATA_WIDTH-1:0]    i_read_data;
    logic [2:0]               i_status;

    modport slave (
        input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        input  i_response_ready, i_read_data, i_status,
        output o_pready, o_prdata, o_pslverr,
        output o_command_valid, o_write, o_address, o_write_data
    );

    modport master (
        output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        output i_response_ready, i_read_data, i_status,
        input  o_pready, o_prdata, o_pslverr,
        input  o_command_valid, o_write, o_address, o_write_data
    );
endinterface

// File: rtl/rgen_apb_command_bridge.sv
// APB3 slave front end: turns each transfer into one register-block command, waits for the
// registered response (or a timeout), then completes the APB access with PRDATA/PSLVERR.
module rgen_apb_command_bridge #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic                      clk,
    input logic                      rst_n,
    rgen_apb_command_bridge_if.slave bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(DATA_WIDTH / 8 - 1);

    typedef enum logic [1:0] {IDLE, COMMAND, RESPONSE} state_t;

    state_t                   state, state_nxt;
    logic                     cmd_write, cmd_write_nxt;
    logic [ADDRESS_WIDTH-1:0] cmd_addr, cmd_addr_nxt;
    logic [DATA_WIDTH-1:0]    cmd_wdata, cmd_wdata_nxt;
    logic [DATA_WIDTH-1:0]    rdata, rdata_nxt;
    logic                     err, err_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic                     unused_exokay;

    // exokay carries no information for APB3, only the two error flags matter
    assign unused_exokay = bus.i_status[2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            cmd_write <= cmd_write_nxt;
            cmd_addr  <= cmd_addr_nxt;
            cmd_wdata <= cmd_wdata_nxt;
            rdata     <= rdata_nxt;
            err       <= err_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cmd_write_nxt = cmd_write;
        cmd_addr_nxt  = cmd_addr;
        cmd_wdata_nxt = cmd_wdata;
        rdata_nxt     = rdata;
        err_nxt       = err;
        cnt_nxt       = '0;
        case (state)
            IDLE: begin
                if (bus.i_psel && !bus.i_penable) begin
                    cmd_write_nxt = bus.i_pwrite;
                    cmd_addr_nxt  = bus.i_paddr;
                    cmd_wdata_nxt = bus.i_pwdata;
                    // misaligned accesses never reach the register block
                    if (|(bus.i_paddr & ALIGN_MASK)) begin
                        rdata_nxt = '0;
                        err_nxt   = 1'b1;
                        state_nxt = RESPONSE;
                    end else begin
                        state_nxt = COMMAND;
                    end
                end
            end
            COMMAND: begin
                cnt_nxt = cnt + 1'b1;
                if (bus.i_response_ready) begin
                    rdata_nxt = cmd_write ? '0 : bus.i_read_data;
                    err_nxt   = bus.i_status[0] | bus.i_status[1];
                    state_nxt = RESPONSE;
                end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                    state_nxt = RESPONSE;
                end
            end
            RESPONSE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    assign bus.o_pready        = (state == RESPONSE);
    assign bus.o_prdata        = (state == RESPONSE) ? rdata : '0;
    assign bus.o_pslverr       = (state == RESPONSE) && err;
    assign bus.o_command_valid = (state == COMMAND);
    assign bus.o_write         = cmd_write;
    assign bus.o_address       = cmd_addr;
    assign bus.o_write_data    = cmd_wdata;
endmodule

// File: tb/tb_rgen_apb_command_bridge.sv
// Directed bench for the APB command bridge: transaction-level reference model compared
// every cycle, plus literal checks on latency, timeout, alignment and reset behaviour.
module tb_rgen_apb_command_bridge;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_on = 1'b0;
    int   p0_cnt = 0;

    always #5 clk = ~clk;

    rgen_apb_command_bridge_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    rgen_apb_command_bridge_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

    rgen_apb_command_bridge #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Same stimulus, timeout disabled
    rgen_apb_command_bridge #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );

    assign bus0.i_psel           = bus.i_psel;
    assign bus0.i_penable        = bus.i_penable;
    assign bus0.i_pwrite         = bus.i_pwrite;
    assign bus0.i_paddr          = bus.i_paddr;
    assign bus0.i_pwdata         = bus.i_pwdata;
    assign bus0.i_response_ready = bus.i_response_ready;
    assign bus0.i_read_data      = bus.i_read_data;
    assign bus0.i_status         = bus.i_status;

    always @(posedge clk) if (bus0.o_pready === 1'b1) p0_cnt <= p0_cnt + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: a transfer is either presenting its command, or showing
    // its one-cycle response; new setups are only taken when neither is in progress.
    bit          m_cmd, m_resp, m_w, m_err;
    logic [15:0] m_a;
    logic [31:0] m_d, m_rd;
    int          m_wait;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cmd <= 0; m_resp <= 0; m_w <= 0; m_err <= 0;
            m_a <= '0; m_d <= '0; m_rd <= '0; m_wait <= 0;
        end else if (m_resp) begin
            m_resp <= 0;
        end else if (m_cmd) begin
            if (bus.i_response_ready) begin
                m_cmd <= 0; m_resp <= 1;
                m_rd  <= m_w ? 32'h0 : bus.i_read_data;
                m_err <= bus.i_status[0] | bus.i_status[1];
            end else if (TO != 0 && m_wait + 1 == TO) begin
                m_cmd <= 0; m_resp <= 1; m_rd <= '0; m_err <= 1;
            end
            m_wait <= m_wait + 1;
        end else if (bus.i_psel && !bus.i_penable) begin
            m_w <= bus.i_pwrite; m_a <= bus.i_paddr; m_d <= bus.i_pwdata;
            if (bus.i_paddr % (DW / 8) != 0) begin
                m_resp <= 1; m_err <= 1; m_rd <= '0;
            end else begin
                m_cmd <= 1; m_wait <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pready",        64'(bus.o_pready),        64'(m_resp));
            chk("prdata",        64'(bus.o_prdata),        m_resp ? 64'(m_rd) : 64'h0);
            chk("pslverr",       64'(bus.o_pslverr),       64'(m_resp & m_err));
            chk("command_valid", 64'(bus.o_command_valid), 64'(m_cmd));
            chk("write",         64'(bus.o_write),         64'(m_w));
            chk("address",       64'(bus.o_address),       64'(m_a));
            chk("write_data",    64'(bus.o_write_data),    64'(m_d));
        end
    end

    // Runs one transfer starting just after a rising edge; the register-block response is
    // asserted in cycles resp_at .. resp_at+resp_len-1 counted from the cycle after setup.
    task automatic xfer(input bit w, input logic [15:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input logic [2:0] st,
                        input int resp_at, input int resp_len, input int max_cyc,
                        output int lat, output int cv, output logic [31:0] got_rd,
                        output logic got_err);
        bus.i_psel = 1; bus.i_penable = 0; bus.i_pwrite = w; bus.i_paddr = a;
        bus.i_pwdata = d; bus.i_read_data = rd; bus.i_status = st;
        bus.i_response_ready = 0;
        lat = 0; cv = 0; got_rd = '0; got_err = 0;
        @(posedge clk); #1;
        bus.i_penable = 1;
        for (int k = 1; k <= max_cyc; k++) begin
            bus.i_response_ready = (resp_at > 0 && k >= resp_at && k < resp_at + resp_len);
            if (bus.o_command_valid) cv++;
            if (bus.o_pready) begin
                lat = k; got_rd = bus.o_prdata; got_err = bus.o_pslverr;
            end
            @(posedge clk); #1;
            if (lat != 0) break;
        end
        if (lat == 0) $display("FAIL xfer_wait: got no pready expected pready within %0d cycles", max_cyc);
        bus.i_psel = 0; bus.i_penable = 0; bus.i_response_ready = 0;
    endtask

    int          lat, cv, p0_before;
    logic [31:0] rdv;
    logic        erv;

    initial begin
        rst_n = 0;
        bus.i_psel = 0; bus.i_penable = 0; bus.i_pwrite = 0; bus.i_paddr = '0;
        bus.i_pwdata = '0; bus.i_response_ready = 0; bus.i_read_data = '0; bus.i_status = '0;
        @(posedge clk); #1;
        chk_on = 1;
        @(posedge clk); #1;
        chk("rst_pready", 64'(bus.o_pready), 64'h0);
        chk("rst_cv",     64'(bus.o_command_valid), 64'h0);
        chk("rst_addr",   64'(bus.o_address), 64'h0);
        rst_n = 1;
        @(posedge clk); #1;

        // write, 1-cycle block with trailing strobe; write returns zero data
        xfer(1, 16'h0010, 32'hDEADBEEF, 32'hFFFFFFFF, 3'b000, 2, 2, 40, lat, cv, rdv, erv);
        chk("wr_lat", 64'(lat), 64'd3);
        chk("wr_rdata", 64'(rdv), 64'h0);
        chk("wr_err", 64'(erv), 64'h0);
        chk("wr_hold_addr", 64'(bus.o_address), 64'h0010);
        chk("wr_hold_data", 64'(bus.o_write_data), 64'hDEADBEEF);
        chk("wr_hold_write", 64'(bus.o_write), 64'h1);

        xfer(0, 16'h0004, 32'h0, 32'h12345678, 3'b001, 2, 2, 40, lat, cv, rdv, erv);
        chk("rd_slverr_data", 64'(rdv), 64'h12345678);
        chk("rd_slverr_err", 64'(erv), 64'h1);
        xfer(0, 16'h0004, 32'h0, 32'h12345678, 3'b100, 2, 2, 40, lat, cv, rdv, erv);
        chk("rd_exokay_err", 64'(erv), 64'h0);
        chk("rd_exokay_lat", 64'(lat), 64'd3);
        xfer(0, 16'h0004, 32'h0, 32'h87654321, 3'b010, 2, 2, 40, lat, cv, rdv, erv);
        chk("rd_decerr_err", 64'(erv), 64'h1);

        // misaligned: answered straight after setup, block never sees a command
        xfer(0, 16'h0006, 32'h0, 32'h5A5A5A5A, 3'b000, 1, 3, 40, lat, cv, rdv, erv);
        chk("mis_lat", 64'(lat), 64'd1);
        chk("mis_cv", 64'(cv), 64'd0);
        chk("mis_err", 64'(erv), 64'h1);
        chk("mis_rdata", 64'(rdv), 64'h0);

        // no response: forced error after 16 command cycles; the no-timeout copy keeps waiting
        p0_before = p0_cnt;
        xfer(0, 16'h0008, 32'h0, 32'h0, 3'b000, 0, 0, 40, lat, cv, rdv, erv);
        chk("to_lat", 64'(lat), 64'd17);
        chk("to_cv", 64'(cv), 64'd16);
        chk("to_err", 64'(erv), 64'h1);
        chk("to_rdata", 64'(rdv), 64'h0);
        repeat (20) @(posedge clk);
        #1;
        chk("to0_cv", 64'(bus0.o_command_valid), 64'h1);
        chk("to0_no_pready", 64'(p0_cnt - p0_before), 64'd0);
        bus.i_read_data = 32'hCAFEF00D; bus.i_status = 3'b000; bus.i_response_ready = 1;
        @(posedge clk); #1;
        bus.i_response_ready = 0;
        chk("to0_pready", 64'(bus0.o_pready), 64'h1);
        chk("to0_rdata", 64'(bus0.o_prdata), 64'hCAFEF00D);
        chk("to0_err", 64'(bus0.o_pslverr), 64'h0);
        @(posedge clk); #1;

        // back-to-back with stray strobes landing in each RESPONSE
        xfer(0, 16'h0020, 32'h0, 32'hAAAA5555, 3'b000, 2, 2, 40, lat, cv, rdv, erv);
        chk("b2b1_rdata", 64'(rdv), 64'hAAAA5555);
        xfer(0, 16'h0024, 32'h0, 32'h0F0F0F0F, 3'b000, 2, 2, 40, lat, cv, rdv, erv);
        chk("b2b2_rdata", 64'(rdv), 64'h0F0F0F0F);
        chk("b2b2_lat", 64'(lat), 64'd3);

        // reset while presenting a command
        bus.i_psel = 1; bus.i_penable = 0; bus.i_pwrite = 0; bus.i_paddr = 16'h0030;
        @(posedge clk); #1;
        bus.i_penable = 1;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1; bus.i_psel = 0; bus.i_penable = 0;
        chk("mrst_cv", 64'(bus.o_command_valid), 64'h0);
        chk("mrst_addr", 64'(bus.o_address), 64'h0);
        chk("mrst_pready", 64'(bus.o_pready), 64'h0);
        chk("mrst_cv0", 64'(bus0.o_command_valid), 64'h0);
        xfer(1, 16'h0040, 32'h55AA55AA, 32'h0, 3'b000, 2, 2, 40, lat, cv, rdv, erv);
        chk("post_rst_lat", 64'(lat), 64'd3);
        chk("post_rst_err", 64'(erv), 64'h0);
        chk("post_rst_data", 64'(bus.o_write_data), 64'h55AA55AA);

        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rgen_apb_command_bridge.md
Name: rgen_apb_command_bridge

Overview:
- Host-side front end of a generated register block. It accepts APB3 slave transfers and turns each one into a single register-block command (valid, address, direction, write data).
- It waits for the block's registered response (response ready, read data, 3-bit status) and completes the APB transfer with PRDATA and PSLVERR.
- It sits between the system APB interconnect and the register block's address decoder and response mux. It also adds an alignment check and a response timeout.

Parameters:
- ADDRESS_WIDTH, 16, byte address width of PADDR and o_address
- DATA_WIDTH, 32, data width; must be 8, 16, 32 or 64
- TIMEOUT_CYCLES, 16, max COMMAND-state cycles before forced error; 0 disables the timeout

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset
- i_psel  input  1  APB select
- i_penable  input  1  APB enable
- i_pwrite  input  1  APB direction, 1 = write
- i_paddr  input  ADDRESS_WIDTH  APB byte address
- i_pwdata  input  DATA_WIDTH  APB write data
- o_pready  output  1  APB ready
- o_prdata  output  DATA_WIDTH  APB read data
- o_pslverr  output  1  APB error
- o_command_valid  output  1  command to register block
- o_write  output  1  command direction, 1 = write
- o_address  output  ADDRESS_WIDTH  command byte address
- o_write_data  output  DATA_WIDTH  command write data
- i_response_ready  input  1  response strobe from register block
- i_read_data  input  DATA_WIDTH  response read data
- i_status  input  3  {exokay, decode_error, slave_error}

Behaviour:
- Reset: rst_n is sampled only on the rising clk edge. When low, go to IDLE and drive all outputs and internal registers to 0. Reset mid-transfer abandons the transfer with no response.
- FSM states: IDLE, COMMAND, RESPONSE.
- IDLE → capture (registered on the clock edge):
  - Triggered by i_psel=1 and i_penable=0 (setup phase).
  - Capture i_pwrite, i_paddr and i_pwdata into command registers.
- IDLE → branch:
  - Aligned address (low log2(DATA_WIDTH/8) bits of i_paddr zero): go to COMMAND.
  - Misaligned address: go directly to RESPONSE with error=1, rdata=0, and no command issued.
- COMMAND:
  - o_command_valid=1. o_write, o_address and o_write_data hold the captured values and stay stable.
  - Timeout counter increments every cycle.
  - On i_response_ready=1: capture rdata (i_read_data if read, 0 if write) and error=(i_status[0] | i_status[1]). i_status[2] is ignored. Go to RESPONSE.
  - Else, if TIMEOUT_CYCLES≠0 and counter == TIMEOUT_CYCLES-1: error=1, rdata=0, go to RESPONSE.
  - A response and timeout in the same cycle resolve as a response (response wins).
- RESPONSE:
  - o_pready=1 for exactly one cycle; o_prdata=rdata, o_pslverr=error. Then go to IDLE and clear the counter.
  - o_command_valid=0.
- Output values outside RESPONSE: o_pready, o_prdata and o_pslverr are 0.
- Command outputs outside COMMAND: o_command_valid is 0. o_write, o_address and o_write_data hold their last captured values.
- i_response_ready is ignored outside COMMAND. The trailing strobe caused by the block registering command_valid must have no effect.
- Latency: setup cycle T0 → command valid T1 → response ready T2 → PREADY T3. This gives 2 wait states for a 1-cycle register block.
- Protocol violation: if i_psel or i_penable drops while busy, the transfer still completes internally and PREADY still pulses for one cycle. A new setup phase is accepted only in IDLE.
- Back-to-back transfers: the setup phase of the next transfer may occur in the cycle after RESPONSE. Zero idle cycles are required between transfers.

Test Plan:
- Write 0xDEADBEEF to 0x0010; block returns status 000 one cycle after valid → o_command_valid high one cycle with o_write=1, o_address=0x0010, o_write_data=0xDEADBEEF; o_pready at T3; o_prdata=0, o_pslverr=0.
- Read 0x0004; block returns read data 0x12345678, status 001 → o_prdata=0x12345678, o_pslverr=1. Repeat with status 100 → o_pslverr=0.
- Read 0x0006 (misaligned, DATA_WIDTH=32) → o_command_valid never asserted; o_pready one cycle after setup with o_pslverr=1, o_prdata=0.
- Read with i_response_ready held 0 → o_command_valid high exactly 16 cycles, then o_pready=1, o_pslverr=1, o_prdata=0. TIMEOUT_CYCLES=0 → waits indefinitely.
- Two back-to-back reads with a second i_response_ready pulse in RESPONSE → each transfer gets its own data. The stray strobe does not shorten or corrupt the second transfer.
- rst_n low for 1 cycle during COMMAND → next cycle all outputs 0, FSM in IDLE. A subsequent write completes normally.
